lcd_nibble_tx: RTL

Physical-layer transmitter for the Spartan-3 starter-kit character LCD in 4-bit mode. It sits directly downstream of instruction_fsm. It accepts one command or character byte (or one init nibble) per request and drives SF_D[11:8], LCD_E, LCD_RS and LCD_RW with HD44780 setup, enable-width, hold and inter-nibble timing. The FSM reduces to issuing start/din/rs and waiting for done.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_nibble_tx.sv | 114 +++++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the Spartan-3 starter-kit character LCD path:
// transmitter state encoding and default 50 MHz timing constants.
package lcd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_SETUP_H = 4'd1,
      ST_EN_H    = 4'd2,
      ST_HOLD_H  = 4'd3,
      ST_GAP     = 4'd4,
      ST_SETUP_L = 4'd5,
      ST_EN_L    = 4'd6,
      ST_HOLD_L  = 4'd7,
      ST_WAIT    = 4'd8
   } lcd_state_t;

   localparam int unsigned T_SETUP      = 2;       // 40 ns
   localparam int unsigned T_EN         = 12;      // 240 ns
   localparam int unsigned T_HOLD       = 1;
   localparam int unsigned T_GAP        = 50;      // 1 us
   localparam int unsigned T_CMD        = 2000;    // 40 us
   localparam int unsigned T_PWRON      = 750000;  // 15 ms
   localparam int unsigned T_INIT_SHORT = 205000;  // 4.1 ms
   localparam int unsigned T_INIT_TINY  = 5000;    // 100 us

endpackage

// File: rtl/lcd_nibble_tx.sv
// 4-bit HD44780 write transmitter: sends one byte (or one upper nibble) per
// accepted start with setup / enable / hold / gap / command-wait timing.
module lcd_nibble_tx #(
   parameter int unsigned T_SETUP = lcd_pkg::T_SETUP,
   parameter int unsigned T_EN    = lcd_pkg::T_EN,
   parameter int unsigned T_HOLD  = lcd_pkg::T_HOLD,
   parameter int unsigned T_GAP   = lcd_pkg::T_GAP,
   parameter int unsigned T_CMD   = lcd_pkg::T_CMD,
   parameter int unsigned CNT_W   = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] din,
   input  logic       rs_in,
   input  logic       nibble_only,
   output logic       busy,
   output logic       done,
   output logic [3:0] SF_D,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW
);
   import lcd_pkg::*;

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);

   lcd_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       lo_q;
   logic             nib_q;

   always_ff @(posedge clk) begin
      LCD_RW <= 1'b0;
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         SF_D   <= '0;
         LCD_E  <= 1'b0;
         LCD_RS <= 1'b0;
         lo_q   <= '0;
         nib_q  <= 1'b0;
      end else begin
         done <= 1'b0;
         cnt  <= cnt + 1'b1;
         unique case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (start) begin
                  state  <= ST_SETUP_H;
                  busy   <= 1'b1;
                  SF_D   <= din[7:4];
                  LCD_RS <= rs_in;
                  lo_q   <= din[3:0];
                  nib_q  <= nibble_only;
               end
            end
            ST_SETUP_H: if (cnt == SETUP_LAST) begin
               state <= ST_EN_H;
               cnt   <= '0;
               LCD_E <= 1'b1;
            end
            ST_EN_H: if (cnt == EN_LAST) begin
               state <= ST_HOLD_H;
               cnt   <= '0;
               LCD_E <= 1'b0;
            end
            // init writes skip the lower nibble and go straight to the wait
            ST_HOLD_H: if (cnt == HOLD_LAST) begin
               state <= nib_q ? ST_WAIT : ST_GAP;
               cnt   <= '0;
            end
            ST_GAP: if (cnt == GAP_LAST) begin
               state <= ST_SETUP_L;
               cnt   <= '0;
               SF_D  <= lo_q;
            end
            ST_SETUP_L: if (cnt == SETUP_LAST) begin
               state <= ST_EN_L;
               cnt   <= '0;
               LCD_E <= 1'b1;
            end
            ST_EN_L: if (cnt == EN_LAST) begin
               state <= ST_HOLD_L;
               cnt   <= '0;
               LCD_E <= 1'b0;
            end
            ST_HOLD_L: if (cnt == HOLD_LAST) begin
               state <= ST_WAIT;
               cnt   <= '0;
            end
            ST_WAIT: if (cnt == CMD_LAST) begin
               state <= ST_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
               LCD_E <= 1'b0;
            end
         endcase
      end
   end

endmodule
